sht40_meas_ctrl: RTL and testbench

- Sequences one complete SHT40 measurement transaction over the byte-level I2C engine, which is built on the SCL/SDA line drivers.
- Transaction: write the measure command, wait for conversion, read 6 bytes, CRC-check both words.
- Presents raw temperature and humidity words to the processor side, plus error flags.
- Sits between the processor-facing register logic and the I2C byte engine. It is the only client of that engine.

---
 rtl/sht40_pkg.sv | 30 +++
 rtl/sht40_crc8.sv | 16 +
 rtl/sht40_meas_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sht40_meas_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sht40_pkg.sv
// sht40_pkg: shared op codes, FSM states and constants for the SHT40 measurement controller
package sht40_pkg;

    typedef enum logic [2:0] {
        OP_START_WRITE = 3'd0,
        OP_START_READ  = 3'd1,
        OP_WRITE       = 3'd2,
        OP_READ_ACK    = 3'd3,
        OP_READ_NACK   = 3'd4,
        OP_STOP        = 3'd5
    } op_e;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_W_ADDR = 4'd1;
    localparam logic [3:0] ST_W_CMD  = 4'd2;
    localparam logic [3:0] ST_W_STOP = 4'd3;
    localparam logic [3:0] ST_WAIT   = 4'd4;
    localparam logic [3:0] ST_R_ADDR = 4'd5;
    localparam logic [3:0] ST_R_BYTE = 4'd6;
    localparam logic [3:0] ST_R_STOP = 4'd7;
    localparam logic [3:0] ST_CHECK  = 4'd8;
    localparam logic [3:0] ST_ABORT  = 4'd9;

    localparam logic [7:0] CRC_POLY = 8'h31;
    localparam logic [7:0] CRC_INIT = 8'hFF;

    localparam logic [6:0] DEF_I2C_ADDR = 7'h44;
    localparam logic [7:0] DEF_MEAS_CMD = 8'hFD;

endpackage

// File: rtl/sht40_crc8.sv
// sht40_crc8: combinational CRC-8 (poly 0x31, init 0xFF, MSB first) over one 16-bit word
module sht40_crc8
    import sht40_pkg::*;
(
    input  logic [15:0] data_i,
    output logic [7:0]  crc_o
);

    // shift the word through the LFSR one bit at a time, MSB first
    always_comb begin
        crc_o = CRC_INIT;
        for (int i = 15; i >= 0; i--)
            crc_o = (crc_o[7] ^ data_i[i]) ? ({crc_o[6:0], 1'b0} ^ CRC_POLY) : {crc_o[6:0], 1'b0};
    end

endmodule

// File: rtl/sht40_meas_ctrl.sv
// sht40_meas_ctrl: sequences one SHT40 measure/wait/read transaction over the I2C byte engine
module sht40_meas_ctrl
    import sht40_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = DEF_I2C_ADDR,
    parameter logic [7:0] MEAS_CMD    = DEF_MEAS_CMD,
    parameter int         WAIT_CYCLES = 1000000,
    parameter int         CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] temp_raw,
    output logic [15:0] hum_raw,
    output logic        crc_err,
    output logic        nack_err,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       state_q, state_d;
    logic             issued_q, issued_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       rx_q [6];
    logic [7:0]       rx_d [6];
    logic [15:0]      temp_q, temp_d, hum_q, hum_d;
    logic             crc_err_q, crc_err_d, nack_err_q, nack_err_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             cmd_active, rsp_ok;
    logic [7:0]       crc_temp, crc_hum;
    op_e              op;

    sht40_crc8 u_crc_temp (.data_i({rx_q[0], rx_q[1]}), .crc_o(crc_temp));
    sht40_crc8 u_crc_hum  (.data_i({rx_q[3], rx_q[4]}), .crc_o(crc_hum));

    // a command state first presents its command, then waits for the engine's single response
    always_comb begin
        cmd_active = state_q == ST_W_ADDR || state_q == ST_W_CMD || state_q == ST_W_STOP ||
                     state_q == ST_R_ADDR || state_q == ST_R_BYTE || state_q == ST_R_STOP ||
                     state_q == ST_ABORT;
        rsp_ok     = cmd_active && issued_q && rsp_valid;
        op         = !cmd_active            ? OP_START_WRITE :
                     state_q == ST_W_ADDR   ? OP_START_WRITE :
                     state_q == ST_W_CMD    ? OP_WRITE :
                     state_q == ST_R_ADDR   ? OP_START_READ :
                     state_q == ST_R_BYTE   ? (idx_q == 3'd5 ? OP_READ_NACK : OP_READ_ACK) :
                                              OP_STOP;
        cmd_data   = state_q == ST_W_ADDR ? {I2C_ADDR, 1'b0} :
                     state_q == ST_W_CMD  ? MEAS_CMD :
                     state_q == ST_R_ADDR ? {I2C_ADDR, 1'b1} : 8'h00;
    end

    assign cmd_valid = cmd_active && !issued_q;
    assign cmd_op    = op;
    assign busy      = busy_q;
    assign done      = done_q;
    assign temp_raw  = temp_q;
    assign hum_raw   = hum_q;
    assign crc_err   = crc_err_q;
    assign nack_err  = nack_err_q;

    // transaction sequencing, byte capture and result/flag update
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rx_d       = rx_q;
        temp_d     = temp_q;
        hum_d      = hum_q;
        crc_err_d  = crc_err_q;
        nack_err_d = nack_err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (cmd_valid && cmd_ready) issued_d = 1'b1;
        if (rsp_ok) issued_d = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_W_ADDR;
                busy_d     = 1'b1;
                crc_err_d  = 1'b0;
                nack_err_d = 1'b0;
            end
            ST_W_ADDR: if (rsp_ok) state_d = rsp_nack ? ST_ABORT : ST_W_CMD;
            ST_W_CMD:  if (rsp_ok) state_d = rsp_nack ? ST_ABORT : ST_W_STOP;
            ST_W_STOP: if (rsp_ok) begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: if (cnt_q == CNT_LAST) state_d = ST_R_ADDR;
                     else cnt_d = cnt_q + CNT_ONE;
            ST_R_ADDR: if (rsp_ok) begin
                state_d = rsp_nack ? ST_ABORT : ST_R_BYTE;
                idx_d   = 3'd0;
            end
            ST_R_BYTE: if (rsp_ok) begin
                rx_d[idx_q] = rsp_data;
                if (idx_q == 3'd5) state_d = ST_R_STOP;
                else idx_d = idx_q + 3'd1;
            end
            ST_R_STOP: if (rsp_ok) state_d = ST_CHECK;
            ST_CHECK: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                if (crc_temp == rx_q[2] && crc_hum == rx_q[5]) begin
                    temp_d = {rx_q[0], rx_q[1]};
                    hum_d  = {rx_q[3], rx_q[4]};
                end else crc_err_d = 1'b1;
            end
            ST_ABORT: if (rsp_ok) begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                nack_err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state registers, cleared asynchronously so cmd_valid drops as soon as rst_n falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            issued_q   <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            rx_q       <= '{default: 8'h00};
            temp_q     <= 16'h0000;
            hum_q      <= 16'h0000;
            crc_err_q  <= 1'b0;
            nack_err_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rx_q       <= rx_d;
            temp_q     <= temp_d;
            hum_q      <= hum_d;
            crc_err_q  <= crc_err_d;
            nack_err_q <= nack_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_sht40_meas_ctrl.sv
// tb_sht40_meas_ctrl: scoreboard bench with a behavioural I2C byte-engine model
module tb_sht40_meas_ctrl;
    import sht40_pkg::*;

    localparam int WAITC = 10;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
    } cmd_t;

    typedef struct {
        logic [15:0] t;
        logic [15:0] h;
        logic        c;
        logic        n;
    } res_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
    logic [7:0]  rsp_data = 8'h00;
    logic        busy, done, crc_err, nack_err, cmd_valid;
    logic [15:0] temp_raw, hum_raw;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;

    int tests = 0, fails = 0;
    int stall_n = 0, nack_sel = 0;
    int cyc = 0, last_rsp_cyc = 0, lat = 0, stall_left = 0, rd_idx = 0, done_cnt = 0;
    bit pending = 0, prev_v = 0, have_last = 0, prev_done = 0;
    logic [2:0]  hold_op, acc_op;
    logic [7:0]  hold_data;
    logic [47:0] cur_frame = '0;
    logic [15:0] m_temp = 16'h0000, m_hum = 16'h0000;
    cmd_t        exp_cmd[$];
    res_t        exp_res[$];
    logic [47:0] frame_q[$];
    cmd_t        e;
    res_t        r;

    sht40_meas_ctrl #(.WAIT_CYCLES(WAITC), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .temp_raw(temp_raw), .hum_raw(hum_raw), .crc_err(crc_err), .nack_err(nack_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        c = 8'hFF ^ a;
        repeat (8) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        c = c ^ b;
        repeat (8) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        return c;
    endfunction

    function automatic logic [47:0] good_frame(input logic [15:0] t, input logic [15:0] h);
        return {t, crc8(t[15:8], t[7:0]), h, crc8(h[15:8], h[7:0])};
    endfunction

    // byte-engine model: optional backpressure, response 3 cycles after acceptance
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            pending = 0; rsp_valid = 0; rsp_nack = 0; rsp_data = 0; cmd_ready = 0; prev_v = 0; have_last = 0;
        end else begin
            rsp_valid = 0; rsp_nack = 0; rsp_data = 0;
            if (pending) begin
                cmd_ready = 0;
                tests++;
                if (cmd_valid) begin
                    fails++;
                    $display("FAIL outstanding: cmd_valid=%0b while a command is in flight, required 0", cmd_valid);
                end
                lat--;
                if (lat == 0) begin
                    pending = 0; rsp_valid = 1; last_rsp_cyc = cyc; have_last = 1;
                    case (acc_op)
                        OP_START_WRITE: rsp_nack = (nack_sel == 1);
                        OP_WRITE:       rsp_nack = (nack_sel == 2);
                        OP_START_READ: begin
                            rsp_nack  = (nack_sel == 3);
                            cur_frame = frame_q.size() > 0 ? frame_q.pop_front() : 48'h0;
                            rd_idx    = 0;
                        end
                        OP_READ_ACK, OP_READ_NACK: begin
                            rsp_data = rd_idx < 6 ? 8'(cur_frame >> (8 * (5 - rd_idx))) : 8'h00;
                            rd_idx++;
                        end
                        default: ;
                    endcase
                end
            end else if (cmd_valid) begin
                if (!prev_v) begin
                    tests++;
                    if (exp_cmd.size() == 0) begin
                        fails++;
                        $display("FAIL cmd_unexpected: op=%0d data=%h, required no command", cmd_op, cmd_data);
                    end else begin
                        e = exp_cmd.pop_front();
                        if (cmd_op !== e.op || cmd_data !== e.data) begin
                            fails++;
                            $display("FAIL cmd: op=%0d data=%h, required op=%0d data=%h", cmd_op, cmd_data, e.op, e.data);
                        end
                    end
                    if (have_last) begin
                        tests++;
                        if (cyc - last_rsp_cyc - 1 != (cmd_op == OP_START_READ ? WAITC : 0)) begin
                            fails++;
                            $display("FAIL cmd_gap: op=%0d idle=%0d, required %0d", cmd_op, cyc - last_rsp_cyc - 1,
                                     cmd_op == OP_START_READ ? WAITC : 0);
                        end
                    end
                    hold_op = cmd_op; hold_data = cmd_data; stall_left = stall_n;
                end else begin
                    tests++;
                    if (cmd_op !== hold_op || cmd_data !== hold_data) begin
                        fails++;
                        $display("FAIL cmd_stable: op=%0d data=%h, required op=%0d data=%h", cmd_op, cmd_data, hold_op, hold_data);
                    end
                end
                prev_v = 1;
                if (stall_left > 0) begin
                    cmd_ready = 0; stall_left--;
                end else begin
                    cmd_ready = 1; pending = 1; lat = 3; acc_op = cmd_op; prev_v = 0;
                end
            end else begin
                cmd_ready = 0; prev_v = 0;
            end
        end
    end

    // result monitor: every done pulse pops and checks one expected result
    initial forever begin
        @(negedge clk);
        if (rst_n && done) begin
            done_cnt++;
            have_last = 0;
            tests++;
            if (exp_res.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: done=1, required no done");
            end else begin
                r = exp_res.pop_front();
                if (temp_raw !== r.t || hum_raw !== r.h || crc_err !== r.c || nack_err !== r.n || busy !== 1'b0 || prev_done) begin
                    fails++;
                    $display("FAIL result: temp=%h hum=%h crc=%b nack=%b busy=%b prev_done=%b, required temp=%h hum=%h crc=%b nack=%b busy=0 prev_done=0",
                             temp_raw, hum_raw, crc_err, nack_err, busy, prev_done, r.t, r.h, r.c, r.n);
                end
            end
        end
        prev_done = rst_n && done;
    end

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] d);
        cmd_t c;
        c.op = op; c.data = d;
        exp_cmd.push_back(c);
    endtask

    task automatic prepare(input logic [47:0] f, input int ns);
        res_t x;
        logic good;
        good = crc8(f[47:40], f[39:32]) == f[31:24] && crc8(f[23:16], f[15:8]) == f[7:0];
        push_cmd(OP_START_WRITE, 8'h88);
        if (ns == 1) push_cmd(OP_STOP, 8'h00);
        else begin
            push_cmd(OP_WRITE, 8'hFD);
            push_cmd(OP_STOP, 8'h00);
            if (ns != 2) begin
                push_cmd(OP_START_READ, 8'h89);
                frame_q.push_back(f);
                if (ns != 3) begin
                    repeat (5) push_cmd(OP_READ_ACK, 8'h00);
                    push_cmd(OP_READ_NACK, 8'h00);
                end
                push_cmd(OP_STOP, 8'h00);
            end
        end
        if (ns == 0 && good) begin
            m_temp = f[47:32];
            m_hum  = f[23:8];
        end
        x.t = m_temp; x.h = m_hum; x.c = ns == 0 && !good; x.n = ns != 0;
        exp_res.push_back(x);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c0, n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done_cnt == c0) begin
            fails++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done", name, budget);
        end
        tests++;
        if (exp_cmd.size() != 0 || exp_res.size() != 0) begin
            fails++;
            $display("FAIL %s_pending: %0d commands and %0d results outstanding, required 0 and 0", name, exp_cmd.size(), exp_res.size());
        end
    endtask

    task automatic wait_cmd(input logic [2:0] op, input string name);
        int n;
        n = 0;
        while (!(cmd_valid && cmd_op == op) && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(cmd_valid && cmd_op == op)) begin
            fails++;
            $display("FAIL %s_wait: cmd op=%0d valid=%b, required op=%0d valid=1", name, cmd_op, cmd_valid, op);
        end
    endtask

    task automatic run_txn(input logic [47:0] f, input int ns, input string name);
        prepare(f, ns);
        pulse_start();
        wait_done(name, 600);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_busy: busy=%b, required 0", name, busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({busy, done, temp_raw, hum_raw, crc_err, nack_err, cmd_valid, cmd_op, cmd_data} !== '0) begin
            fails++;
            $display("FAIL %s: busy=%b done=%b temp=%h hum=%h crc=%b nack=%b valid=%b op=%0d data=%h, required all 0",
                     name, busy, done, temp_raw, hum_raw, crc_err, nack_err, cmd_valid, cmd_op, cmd_data);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1;
        repeat (3) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_nominal;
        int c0;
        run_txn(48'hBEEF92_666693, 0, "nominal");
        c0 = done_cnt;
        repeat (20) @(negedge clk);
        tests++;
        if (temp_raw !== 16'hBEEF || hum_raw !== 16'h6666 || crc_err !== 1'b0 || done_cnt != c0) begin
            fails++;
            $display("FAIL nominal_hold: temp=%h hum=%h crc=%b extra_done=%0d, required BEEF 6666 0 0",
                     temp_raw, hum_raw, crc_err, done_cnt - c0);
        end
    endtask

    task automatic test_crc_fail;
        logic [47:0] g;
        run_txn(48'hBEEF93_666693, 0, "crc_temp_bad");
        run_txn(good_frame(16'h1234, 16'h5678), 0, "crc_good");
        g = good_frame(16'hA5A5, 16'h0102);
        run_txn(g ^ 48'h000000_000001, 0, "crc_hum_bad");
        run_txn(g ^ 48'h000100_000000, 0, "crc_temp_bad2");
    endtask

    task automatic test_nack;
        for (int k = 1; k <= 3; k++) begin
            nack_sel = k;
            run_txn(48'hBEEF92_666693, k, "nack");
            repeat (10) @(negedge clk);
        end
        nack_sel = 0;
        run_txn(good_frame(16'h0F0F, 16'hF0F0), 0, "after_nack");
    endtask

    task automatic test_backpressure;
        stall_n = 7;
        run_txn(48'hBEEF92_666693, 0, "backpressure");
        stall_n = 0;
    endtask

    task automatic test_start_ignored;
        int c0, n;
        prepare(good_frame(16'h4321, 16'h8765), 0);
        pulse_start();
        wait_cmd(OP_STOP, "w_stop");
        n = 0;
        while (cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        pulse_start();
        wait_cmd(OP_READ_ACK, "r_byte");
        pulse_start();
        wait_done("start_ignored", 600);
        c0 = done_cnt;
        repeat (30) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done_cnt != c0) begin
            fails++;
            $display("FAIL start_ignored_idle: busy=%b extra_done=%0d, required 0 0", busy, done_cnt - c0);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        prepare(good_frame(16'h1111, 16'h2222), 0);
        prepare(good_frame(16'h3333, 16'h4444), 0);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 600);
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL b2b_first_timeout: done=%b, required 1", done);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_busy: busy=%b, required 1", busy);
        end
        wait_done("b2b_second", 600);
    endtask

    task automatic test_reset_mid;
        prepare(good_frame(16'h5A5A, 16'hC3C3), 0);
        pulse_start();
        wait_cmd(OP_READ_ACK, "mid");
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1 check_all_zero("reset_mid");
        exp_cmd.delete();
        exp_res.delete();
        frame_q.delete();
        m_temp = 16'h0000;
        m_hum  = 16'h0000;
        repeat (3) @(negedge clk);
        check_all_zero("reset_mid_held");
        rst_n = 1;
        run_txn(48'hBEEF92_666693, 0, "after_reset");
    endtask

    task automatic test_random;
        logic [47:0] f;
        for (int k = 0; k < 6; k++) begin
            f = good_frame(16'($urandom), 16'($urandom));
            if (k[0]) f = f ^ (48'h1 << $urandom_range(0, 47));
            run_txn(f, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_crc_fail();
        test_nack();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
